// File: rtl/ddr4_cmd_pkg.sv
// ddr4_cmd_pkg
//   Shared definitions for the DDR4 command front end and the per-bank
//   timing FSM array that consumes its output.
//   - CMD_W / *_IDX : layout of the one-hot command vector
//   - OP_*          : {A16,A15,A14} opcodes seen when act_n=1
//   - pwr_state_t   : CKE power state (INIT/ACTIVE/PWRDN/SELFREF)
package ddr4_cmd_pkg;

  localparam int CMD_W = 19;

  localparam int ACT_IDX  = 18;
  localparam int BST_IDX  = 17;
  localparam int CFG_IDX  = 16;
  localparam int CKEH_IDX = 15;
  localparam int CKEL_IDX = 14;
  localparam int DPD_IDX  = 13;
  localparam int DPDX_IDX = 12;
  localparam int MRR_IDX  = 11;
  localparam int MRW_IDX  = 10;
  localparam int PD_IDX   = 9;
  localparam int PDX_IDX  = 8;
  localparam int PR_IDX   = 7;
  localparam int PRA_IDX  = 6;
  localparam int RD_IDX   = 5;
  localparam int RDA_IDX  = 4;
  localparam int REF_IDX  = 3;
  localparam int SRF_IDX  = 2;
  localparam int WR_IDX   = 1;
  localparam int WRA_IDX  = 0;

  localparam logic [2:0] OP_MRW = 3'b000;
  localparam logic [2:0] OP_REF = 3'b001;
  localparam logic [2:0] OP_PRE = 3'b010;
  localparam logic [2:0] OP_RFU = 3'b011;
  localparam logic [2:0] OP_WR  = 3'b100;
  localparam logic [2:0] OP_RD  = 3'b101;
  localparam logic [2:0] OP_ZQ  = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    ACTIVE  = 2'd1,
    PWRDN   = 2'd2,
    SELFREF = 2'd3
  } pwr_state_t;

endpackage

// File: rtl/ddr4_cke_track.sv
// ddr4_cke_track
//   Registers CKE, detects its edges and runs the CKE power state machine.
//   Ports:
//     clk, reset_n     : command clock, async active-low reset
//     cke              : CKE pin
//     fall_to_selfref  : a REF is on the pins this cycle (picks SELFREF on CKE fall)
//     ckeh, ckel       : combinational rise/fall of cke against the registered copy
//     state            : registered power state
module ddr4_cke_track
  import ddr4_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cke,
  input  logic       fall_to_selfref,
  output logic       ckeh,
  output logic       ckel,
  output pwr_state_t state
);

  logic       cke_prev;
  pwr_state_t state_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cke_prev <= 1'b0;
      state    <= INIT;
    end else begin
      cke_prev <= cke;
      state    <= state_next;
    end
  end

  assign ckeh = !cke_prev && cke;
  assign ckel = cke_prev && !cke;

  // A CKE fall can only happen from ACTIVE, since every other state is
  // entered or held with cke low; any rise brings the device back to ACTIVE.
  always_comb begin
    state_next = state;
    unique case (state)
      INIT:          if (ckeh) state_next = ACTIVE;
      ACTIVE:        if (ckel) state_next = fall_to_selfref ? SELFREF : PWRDN;
      PWRDN,
      SELFREF:       if (ckeh) state_next = ACTIVE;
      default:       state_next = INIT;
    endcase
  end

endmodule

// File: rtl/ddr4_cmd_decode.sv
// ddr4_cmd_decode
//   Samples the DDR4 command/address pins and produces a registered one-hot
//   command vector with aligned bank-group/bank/row/column fields.
//   Ports:
//     clk, reset_n            : command clock, async active-low reset
//     cke, cs_n, act_n        : control pins
//     bg, ba, a               : bank group, bank and address pins (A16..A14 = RAS/CAS/WE)
//     commands                : one-hot command vector (see ddr4_cmd_pkg indices)
//     bg_q, ba_q, row_q, col_q: address fields, updated only by bank-addressed commands
//     pwr_state               : CKE power state
//     err                     : sticky illegal-command flag, cleared by reset only
module ddr4_cmd_decode
  import ddr4_cmd_pkg::*;
#(
  parameter int BGWIDTH = 2,
  parameter int BAWIDTH = 2,
  parameter int AWIDTH  = 18
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cke,
  input  logic               cs_n,
  input  logic               act_n,
  input  logic [BGWIDTH-1:0] bg,
  input  logic [BAWIDTH-1:0] ba,
  input  logic [AWIDTH-1:0]  a,
  output logic [CMD_W-1:0]   commands,
  output logic [BGWIDTH-1:0] bg_q,
  output logic [BAWIDTH-1:0] ba_q,
  output logic [AWIDTH-1:0]  row_q,
  output logic [9:0]         col_q,
  output logic [1:0]         pwr_state,
  output logic               err
);

  logic       ckeh;
  logic       ckel;
  pwr_state_t state;

  logic [2:0]       op;
  logic [CMD_W-1:0] raw_cmd;
  logic             raw_rfu;
  logic             raw_quiet;
  logic [CMD_W-1:0] cmd_next;
  logic             err_set;
  logic             upd_bank;
  logic             upd_row;
  logic             upd_col;

  assign op = {a[16], a[15], a[14]};

  ddr4_cke_track u_cke_track (
    .clk             (clk),
    .reset_n         (reset_n),
    .cke             (cke),
    .fall_to_selfref (raw_cmd[REF_IDX]),
    .ckeh            (ckeh),
    .ckel            (ckel),
    .state           (state)
  );

  // Pin-level truth table, independent of power state. raw_quiet marks
  // DES/NOP, the only pin patterns allowed while CKE is low.
  always_comb begin
    raw_cmd   = '0;
    raw_rfu   = 1'b0;
    raw_quiet = cs_n;
    if (!cs_n) begin
      if (!act_n) begin
        raw_cmd[ACT_IDX] = 1'b1;
      end else begin
        unique case (op)
          OP_MRW:  raw_cmd[MRW_IDX] = 1'b1;
          OP_REF:  raw_cmd[REF_IDX] = 1'b1;
          OP_PRE:  raw_cmd[a[10] ? PRA_IDX : PR_IDX] = 1'b1;
          OP_WR:   raw_cmd[a[10] ? WRA_IDX : WR_IDX] = 1'b1;
          OP_RD:   raw_cmd[a[10] ? RDA_IDX : RD_IDX] = 1'b1;
          OP_ZQ:   raw_cmd[CFG_IDX] = 1'b1;
          OP_NOP:  raw_quiet = 1'b1;
          OP_RFU:  raw_rfu = 1'b1;
          default: raw_rfu = 1'b1;
        endcase
      end
    end
  end

  // Combine pin decode with the power state. A CKE fall converts REF into
  // self-refresh entry and DES/NOP into power-down entry; anything else on
  // the falling cycle is dropped and flagged. In INIT nothing is flagged.
  always_comb begin
    cmd_next           = '0;
    err_set            = 1'b0;
    cmd_next[CKEH_IDX] = ckeh;
    cmd_next[CKEL_IDX] = ckel;
    unique case (state)
      ACTIVE: begin
        if (ckel) begin
          if (raw_cmd[REF_IDX]) begin
            cmd_next[SRF_IDX] = 1'b1;
          end else if (raw_quiet) begin
            cmd_next[PD_IDX] = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end else begin
          cmd_next = cmd_next | raw_cmd;
          err_set  = raw_rfu;
        end
      end
      PWRDN: begin
        if (ckeh) begin
          cmd_next[PDX_IDX] = 1'b1;
        end else begin
          err_set = !raw_quiet;
        end
      end
      SELFREF: begin
        if (!ckeh) begin
          err_set = !raw_quiet;
        end
      end
      default: begin
      end
    endcase
  end

  assign upd_row  = cmd_next[ACT_IDX];
  assign upd_col  = cmd_next[RD_IDX] | cmd_next[RDA_IDX] |
                    cmd_next[WR_IDX] | cmd_next[WRA_IDX];
  assign upd_bank = upd_row | upd_col | cmd_next[PR_IDX];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commands <= '0;
      bg_q     <= '0;
      ba_q     <= '0;
      row_q    <= '0;
      col_q    <= '0;
      err      <= 1'b0;
    end else begin
      commands <= cmd_next;
      err      <= err | err_set;
      if (upd_bank) begin
        bg_q <= bg;
        ba_q <= ba;
      end
      if (upd_row) row_q <= a;
      if (upd_col) col_q <= a[9:0];
    end
  end

  assign pwr_state = state;

endmodule

// File: tb/tb_ddr4_cmd_decode.sv
// tb_ddr4_cmd_decode
//   Directed walk through the power/command scenarios followed by random
//   pin traffic, all compared against a command-name level reference model.
module tb_ddr4_cmd_decode;

  localparam int M_INIT    = 0;
  localparam int M_ACTIVE  = 1;
  localparam int M_PWRDN   = 2;
  localparam int M_SELFREF = 3;

  logic        clk;
  logic        reset_n;
  logic        cke;
  logic        cs_n;
  logic        act_n;
  logic [1:0]  bg;
  logic [1:0]  ba;
  logic [17:0] a;
  logic [18:0] commands;
  logic [1:0]  bg_q;
  logic [1:0]  ba_q;
  logic [17:0] row_q;
  logic [9:0]  col_q;
  logic [1:0]  pwr_state;
  logic        err;

  int checks;
  int failures;

  int          cmd_bit [string];
  int          m_state;
  logic        m_err;
  logic [18:0] m_cmd;
  logic [1:0]  m_bg;
  logic [1:0]  m_ba;
  logic [17:0] m_row;
  logic [9:0]  m_col;

  ddr4_cmd_decode dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cke       (cke),
    .cs_n      (cs_n),
    .act_n     (act_n),
    .bg        (bg),
    .ba        (ba),
    .a         (a),
    .commands  (commands),
    .bg_q      (bg_q),
    .ba_q      (ba_q),
    .row_q     (row_q),
    .col_q     (col_q),
    .pwr_state (pwr_state),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic checkAll(input string step);
    checkOutput({step, " commands"}, 32'(commands), 32'(m_cmd));
    checkOutput({step, " pwr_state"}, 32'(pwr_state), 32'(m_state));
    checkOutput({step, " err"}, 32'(err), 32'(m_err));
    checkOutput({step, " bg_q"}, 32'(bg_q), 32'(m_bg));
    checkOutput({step, " ba_q"}, 32'(ba_q), 32'(m_ba));
    checkOutput({step, " row_q"}, 32'(row_q), 32'(m_row));
    checkOutput({step, " col_q"}, 32'(col_q), 32'(m_col));
  endtask

  // Name the command the pins carry, straight from the DDR4 pin table.
  function automatic string classify(input logic i_cs, input logic i_act, input logic [17:0] i_a);
    int code;
    if (i_cs) return "DES";
    if (!i_act) return "ACT";
    code = int'(i_a[16]) * 4 + int'(i_a[15]) * 2 + int'(i_a[14]);
    case (code)
      0: return "MRW";
      1: return "REF";
      2: return i_a[10] ? "PRA" : "PR";
      3: return "RFU";
      4: return i_a[10] ? "WRA" : "WR";
      5: return i_a[10] ? "RDA" : "RD";
      6: return "CFG";
      default: return "NOP";
    endcase
  endfunction

  task automatic modelReset();
    m_state = M_INIT;
    m_err   = 1'b0;
    m_cmd   = '0;
    m_bg    = '0;
    m_ba    = '0;
    m_row   = '0;
    m_col   = '0;
  endtask

  task automatic doReset(input string step);
    reset_n = 1'b0;
    #2;
    modelReset();
    checkAll(step);
    @(posedge clk);
    #1;
    checkAll({step, " held"});
    reset_n = 1'b1;
  endtask

  // Drive one cycle of pins, advance the model by the same cycle and compare.
  task automatic applyStimulus(input string step, input logic i_cke, input logic i_cs, input logic i_act,
                               input logic [1:0] i_bg, input logic [1:0] i_ba, input logic [17:0] i_a);
    string kind;
    logic  quiet;
    cke   = i_cke;
    cs_n  = i_cs;
    act_n = i_act;
    bg    = i_bg;
    ba    = i_ba;
    a     = i_a;
    kind  = classify(i_cs, i_act, i_a);
    quiet = (kind == "DES") || (kind == "NOP");
    m_cmd = '0;
    case (m_state)
      M_INIT: begin
        if (i_cke) begin
          m_cmd[15] = 1'b1;
          m_state   = M_ACTIVE;
        end
      end
      M_ACTIVE: begin
        if (i_cke) begin
          if (cmd_bit.exists(kind)) m_cmd[cmd_bit[kind]] = 1'b1;
          if (kind == "RFU") m_err = 1'b1;
          if (kind == "ACT" || kind == "PR" || kind == "RD" || kind == "RDA" || kind == "WR" || kind == "WRA") begin
            m_bg = i_bg;
            m_ba = i_ba;
          end
          if (kind == "ACT") m_row = i_a;
          if (kind == "RD" || kind == "RDA" || kind == "WR" || kind == "WRA") m_col = i_a[9:0];
        end else begin
          m_cmd[14] = 1'b1;
          if (kind == "REF") begin
            m_cmd[2] = 1'b1;
            m_state  = M_SELFREF;
          end else begin
            if (quiet) m_cmd[9] = 1'b1;
            else m_err = 1'b1;
            m_state = M_PWRDN;
          end
        end
      end
      default: begin
        if (i_cke) begin
          m_cmd[15] = 1'b1;
          if (m_state == M_PWRDN) m_cmd[8] = 1'b1;
          m_state = M_ACTIVE;
        end else if (!quiet) begin
          m_err = 1'b1;
        end
      end
    endcase
    @(posedge clk);
    #1;
    checkAll(step);
  endtask

  function automatic logic [17:0] pins(input int code, input logic a10, input logic [9:0] col);
    logic [17:0] v;
    v        = 18'(col);
    v[10]    = a10;
    v[16:14] = 3'(code);
    return v;
  endfunction

  initial begin
    logic cur_cke;
    checks   = 0;
    failures = 0;
    cmd_bit["ACT"] = 18; cmd_bit["CFG"] = 16; cmd_bit["MRW"] = 10;
    cmd_bit["PR"]  = 7;  cmd_bit["PRA"] = 6;  cmd_bit["RD"]  = 5;
    cmd_bit["RDA"] = 4;  cmd_bit["REF"] = 3;  cmd_bit["WR"]  = 1;
    cmd_bit["WRA"] = 0;
    cke = 1'b0; cs_n = 1'b1; act_n = 1'b1; bg = '0; ba = '0; a = '0;
    modelReset();

    doReset("reset");
    applyStimulus("init_cke0",  1'b0, 1'b0, 1'b1, 2'd0, 2'd0, pins(5, 1'b0, 10'h3));
    applyStimulus("init_cmd",   1'b0, 1'b0, 1'b1, 2'd0, 2'd0, pins(3, 1'b0, 10'h0));
    applyStimulus("cke_rise",   1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 18'h0);
    applyStimulus("act",        1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 18'h1234);
    applyStimulus("act_after",  1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 18'h0);
    applyStimulus("rda",        1'b1, 1'b0, 1'b1, 2'd1, 2'd3, pins(5, 1'b1, 10'h0F8));
    applyStimulus("rd",         1'b1, 1'b0, 1'b1, 2'd3, 2'd2, pins(5, 1'b0, 10'h0F8));
    applyStimulus("wra",        1'b1, 1'b0, 1'b1, 2'd0, 2'd1, pins(4, 1'b1, 10'h155));
    applyStimulus("pra",        1'b1, 1'b0, 1'b1, 2'd2, 2'd2, pins(2, 1'b1, 10'h0));
    applyStimulus("nop",        1'b1, 1'b0, 1'b1, 2'd1, 2'd1, pins(7, 1'b0, 10'h0));
    applyStimulus("sr_entry",   1'b0, 1'b0, 1'b1, 2'd0, 2'd0, pins(1, 1'b0, 10'h0));
    applyStimulus("sr_hold",    1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 18'h0);
    applyStimulus("sr_exit",    1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 18'h0);
    applyStimulus("pd_entry",   1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 18'h0);
    applyStimulus("pd_rd",      1'b0, 1'b0, 1'b1, 2'd1, 2'd1, pins(5, 1'b0, 10'h3FF));
    applyStimulus("pd_exit",    1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 18'h0);
    doReset("reset2");
    applyStimulus("rise2",      1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 18'h0);
    applyStimulus("rfu",        1'b1, 1'b0, 1'b1, 2'd0, 2'd0, pins(3, 1'b0, 10'h0));
    applyStimulus("wr",         1'b1, 1'b0, 1'b1, 2'd3, 2'd0, pins(4, 1'b0, 10'h2A));
    applyStimulus("fall_act",   1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 18'h3FFFF);
    doReset("reset_mid");

    cur_cke = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i % 80 == 79) begin
        doReset("reset_rand");
        cur_cke = 1'b0;
      end
      if ($urandom_range(5) == 0) cur_cke = !cur_cke;
      applyStimulus("rand", cur_cke, ($urandom_range(3) == 0), ($urandom_range(3) != 0),
                    2'($urandom), 2'($urandom), 18'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
